// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO.
//   FIFO_DATA_WIDTH   : default data word width
//   FIFO_DEPTH        : default number of entries
//   fifo_count_width  : width of an occupancy counter holding 0..DEPTH
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 16;
    localparam int FIFO_DEPTH      = 16;

    // Occupancy must represent DEPTH itself, so it needs one bit more than
    // the address.
    function automatic int fifo_count_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port register array with registered read data.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (read data register only)
//   i_wr_en    : write enable
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read enable, loads o_rd_data from i_rd_addr
//   i_rd_addr  : read address
//   o_rd_data  : registered read data, holds when i_rd_en is low
// The storage array itself is never reset.
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // A read and a write to the same address in one cycle returns the old
    // word, which is what a full FIFO doing read+write needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with registered full/empty and programmable
// almost-full/almost-empty flags. Pointers and occupancy are exported.
// Ports:
//   clk, rst           : clock and synchronous active-high reset
//   fifo_data_in       : write data
//   fifo_write         : write request
//   fifo_read          : read request
//   fifo_data_out      : read data, valid one cycle after an accepted read
//   fifo_full/empty    : count == DEPTH / count == 0
//   fifo_almost_full   : count >= AFULL_THRESH
//   fifo_almost_empty  : count <= AEMPTY_THRESH
//   counter_data_out   : occupancy 0..DEPTH
//   wr_ptr, rd_ptr     : next write / read address
// Optional macro SYNC_FIFO_ERR_EN adds sticky fifo_overflow / fifo_underflow
// outputs that record any rejected write / read since the last reset.
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = FIFO_DATA_WIDTH,
    parameter int DEPTH         = FIFO_DEPTH,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_write,
    input  logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [ADDR_WIDTH:0]   counter_data_out,
`ifdef SYNC_FIFO_ERR_EN
    output logic                  fifo_overflow,
    output logic                  fifo_underflow,
`endif
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr
);

    localparam int CNT_W = fifo_count_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    // A write into a full FIFO is accepted only when a read frees a slot in
    // the same cycle; an empty FIFO never bypasses write data to the output.
    assign w_rd_acc = fifo_read && !r_empty;
    assign w_wr_acc = fifo_write && (!r_full || w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Flags are computed from the next count so they line up with
    // counter_data_out in the same cycle. Full comes from the count, so
    // equal pointers are legal both when full and when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == DEPTH_C);
            r_empty  <= (w_count_nxt == '0);
            r_afull  <= (w_count_nxt >= AFULL_C);
            r_aempty <= (w_count_nxt <= AEMPTY_C);
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (fifo_write && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (fifo_read && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign fifo_overflow  = r_overflow;
    assign fifo_underflow = r_underflow;
`endif

    // Requests presented during reset must not disturb memory or read data.
    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc && !rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (fifo_data_in),
        .i_rd_en   (w_rd_acc && !rst),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (fifo_data_out)
    );

    assign fifo_full         = r_full;
    assign fifo_empty        = r_empty;
    assign fifo_almost_full  = r_afull;
    assign fifo_almost_empty = r_aempty;
    assign counter_data_out  = r_count;
    assign wr_ptr            = r_wr_ptr;
    assign rd_ptr            = r_rd_ptr;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst;

    // Instance 1: defaults (16x16, AFULL=14, AEMPTY=2)
    logic [15:0] din, dout;
    logic        wr, rd, full, empty, af, ae;
    logic [4:0]  cnt;
    logic [3:0]  wp, rp;
`ifdef SYNC_FIFO_ERR_EN
    logic        ovf, unf;
`endif

    // Instance 2: AFULL=12, AEMPTY=3
    logic [15:0] din2, dout2;
    logic        wr2, rd2, full2, empty2, af2, ae2;
    logic [4:0]  cnt2;
    logic [3:0]  wp2, rp2;
`ifdef SYNC_FIFO_ERR_EN
    logic        ovf2, unf2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_param u_dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_data_in      (din),
        .fifo_write        (wr),
        .fifo_read         (rd),
        .fifo_data_out     (dout),
        .fifo_full         (full),
        .fifo_empty        (empty),
        .fifo_almost_full  (af),
        .fifo_almost_empty (ae),
        .counter_data_out  (cnt),
`ifdef SYNC_FIFO_ERR_EN
        .fifo_overflow     (ovf),
        .fifo_underflow    (unf),
`endif
        .wr_ptr            (wp),
        .rd_ptr            (rp)
    );

    sync_fifo_param #(
        .AFULL_THRESH  (12),
        .AEMPTY_THRESH (3)
    ) u_dut2 (
        .clk               (clk),
        .rst               (rst),
        .fifo_data_in      (din2),
        .fifo_write        (wr2),
        .fifo_read         (rd2),
        .fifo_data_out     (dout2),
        .fifo_full         (full2),
        .fifo_empty        (empty2),
        .fifo_almost_full  (af2),
        .fifo_almost_empty (ae2),
        .counter_data_out  (cnt2),
`ifdef SYNC_FIFO_ERR_EN
        .fifo_overflow     (ovf2),
        .fifo_underflow    (unf2),
`endif
        .wr_ptr            (wp2),
        .rd_ptr            (rp2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cnt"},   32'(cnt),   32'd0);
        check({tag, "_wp"},    32'(wp),    32'd0);
        check({tag, "_rp"},    32'(rp),    32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full),  32'd0);
        check({tag, "_ae"},    32'(ae),    32'd1);
        check({tag, "_af"},    32'(af),    32'd0);
        check({tag, "_dout"},  32'(dout),  32'd0);
    endtask

    initial begin
        logic [15:0] q[$];
        int          mcnt;
        logic [15:0] exp_d;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; din = '0;
        wr2 = 1'b0; rd2 = 1'b0; din2 = '0;
        step();
        rst = 1'b0;
        check_reset_state("init");
`ifdef SYNC_FIFO_ERR_EN
        check("init_ovf", 32'(ovf), 32'd0);
        check("init_unf", 32'(unf), 32'd0);
`endif

        // 1. Three writes, then reset with a write request pending.
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; din = 16'h0011 * 16'(i + 1);
            step();
        end
        wr = 1'b0;
        check("t1_cnt3", 32'(cnt), 32'd3);
        check("t1_wp3",  32'(wp),  32'd3);
        rst = 1'b1; wr = 1'b1; din = 16'h5555;
        step();
        rst = 1'b0; wr = 1'b0;
        check_reset_state("t1_rst");

        // 2. Fill with 0x0000..0x000F.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; din = 16'(i);
            step();
            check($sformatf("t2_cnt%0d", i), 32'(cnt), 32'(i + 1));
            check($sformatf("t2_af%0d", i), 32'(af), 32'((i + 1) >= 14));
            check($sformatf("t2_ae%0d", i), 32'(ae), 32'((i + 1) <= 2));
            check($sformatf("t2_full%0d", i), 32'(full), 32'(i == 15));
            check($sformatf("t2_empty%0d", i), 32'(empty), 32'd0);
        end
        din = 16'hDEAD;
        step();
        wr = 1'b0;
        check("t2_ovf_wp",   32'(wp),   32'd0);
        check("t2_ovf_cnt",  32'(cnt),  32'd16);
        check("t2_ovf_full", 32'(full), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
        check("t2_ovf_flag", 32'(ovf), 32'd1);
        check("t2_unf_clr",  32'(unf), 32'd0);
`endif

        // 3. Drain, data in order one cycle after each read.
        for (int i = 0; i < 16; i++) begin
            rd = 1'b1;
            step();
            check($sformatf("t3_dout%0d", i), 32'(dout), 32'(i));
            check($sformatf("t3_cnt%0d", i), 32'(cnt), 32'(15 - i));
            check($sformatf("t3_ae%0d", i), 32'(ae), 32'((15 - i) <= 2));
        end
        check("t3_empty", 32'(empty), 32'd1);
        check("t3_full",  32'(full),  32'd0);
        step();
        rd = 1'b0;
        check("t3_unf_rp",   32'(rp),   32'd0);
        check("t3_unf_cnt",  32'(cnt),  32'd0);
        check("t3_unf_dout", 32'(dout), 32'h000F);
`ifdef SYNC_FIFO_ERR_EN
        check("t3_unf_flag", 32'(unf), 32'd1);
        check("t3_ovf_stk",  32'(ovf), 32'd1);
`endif

        // 4. Read+write while full.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; din = 16'h0100 + 16'(i);
            step();
        end
        check("t4_full_pre", 32'(full), 32'd1);
        wr = 1'b1; rd = 1'b1; din = 16'hBEEF;
        step();
        wr = 1'b0;
        check("t4_cnt",  32'(cnt),  32'd16);
        check("t4_full", 32'(full), 32'd1);
        check("t4_dout", 32'(dout), 32'h0100);
        for (int i = 1; i < 16; i++) begin
            step();
            check($sformatf("t4_rd%0d", i), 32'(dout), 32'h0100 + 32'(i));
        end
        step();
        rd = 1'b0;
        check("t4_beef",  32'(dout),  32'hBEEF);
        check("t4_empty", 32'(empty), 32'd1);

        // 5. Read+write while empty: no bypass.
        wr = 1'b1; rd = 1'b1; din = 16'h1234;
        step();
        wr = 1'b0; rd = 1'b0;
        check("t5_cnt",   32'(cnt),   32'd1);
        check("t5_dout",  32'(dout),  32'hBEEF);
        check("t5_empty", 32'(empty), 32'd0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("t5_rd",  32'(dout), 32'h1234);
        check("t5_cnt0", 32'(cnt), 32'd0);

`ifdef SYNC_FIFO_ERR_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_rst_ovf", 32'(ovf), 32'd0);
        check("err_rst_unf", 32'(unf), 32'd0);
`endif

        // 6. Alternating bursts on the second instance (AFULL=12, AEMPTY=3).
        mcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (((c / 10) % 2) == 0) begin
                wr2 = 1'b1; rd2 = 1'b0; din2 = 16'hA000 + 16'(c);
                q.push_back(din2);
                mcnt++;
            end else begin
                wr2 = 1'b0; rd2 = 1'b1;
                mcnt--;
            end
            step();
            if (rd2) begin
                exp_d = q.pop_front();
                check($sformatf("t6_dout%0d", c), 32'(dout2), 32'(exp_d));
            end
            check($sformatf("t6_cnt%0d", c), 32'(cnt2), 32'(mcnt));
            check($sformatf("t6_af%0d", c),  32'(af2),  32'(mcnt >= 12));
            check($sformatf("t6_ae%0d", c),  32'(ae2),  32'(mcnt <= 3));
        end
        wr2 = 1'b0; rd2 = 1'b0;
        check("t6_wp", 32'(wp2), 32'd4);
        check("t6_rp", 32'(rp2), 32'd4);
        // Cross the almost-full threshold exactly.
        for (int i = 1; i <= 12; i++) begin
            wr2 = 1'b1; din2 = 16'(i);
            step();
            check($sformatf("t6_thr_af%0d", i), 32'(af2), 32'(i >= 12));
        end
        wr2 = 1'b0;
        check("t6_thr_wp", 32'(wp2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
